// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared ISA constants and writeback requester IDs for the regfile writeback path.
package regfile_wb_arbiter_pkg;

    localparam int XLEN     = 32;
    localparam int NUM_REGS = 32;
    localparam int RD_W     = 5;
    localparam int NUM_REQ  = 3;

    typedef enum logic [1:0] {
        REQ_ALU = 2'd0,
        REQ_LSU = 2'd1,
        REQ_MDU = 2'd2
    } req_id_e;

    typedef enum logic {
        FAV_LSU = 1'b0,
        FAV_MDU = 1'b1
    } rr_ptr_e;

endpackage

// File: rtl/regfile_wb_arbiter_scoreboard.sv
// Pending-writeback bitmap with same-cycle writeback bypass on the busy query.
module wb_scoreboard #(
    parameter int NUM_REGS = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       issue_valid,
    input  logic [4:0] issue_rd,
    input  logic       wb_wr_en,
    input  logic [4:0] wb_rd,
    input  logic [4:0] rs1_addr,
    input  logic [4:0] rs2_addr,
    output logic       rs1_busy,
    output logic       rs2_busy
);
    import regfile_wb_arbiter_pkg::*;

    logic [NUM_REGS-1:0]       pending_q, pending_d;
    logic [1:0][RD_W-1:0]      rs_addr;
    logic [1:0]                rs_busy;

    // Set is applied after clear so a same-cycle reissue keeps the register busy.
    always_comb begin
        pending_d = pending_q;
        if (wb_wr_en)
            pending_d[wb_rd] = 1'b0;
        if (issue_valid && issue_rd != '0)
            pending_d[issue_rd] = 1'b1;
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset)
            pending_q <= '0;
        else
            pending_q <= pending_d;
    end

    assign rs_addr = {rs2_addr, rs1_addr};

    for (genvar i = 0; i < 2; i++) begin : g_query
        assign rs_busy[i] = (rs_addr[i] != '0) && pending_q[rs_addr[i]] &&
                            !(wb_wr_en && wb_rd == rs_addr[i]);
    end

    assign rs1_busy = rs_busy[0];
    assign rs2_busy = rs_busy[1];

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Three-way regfile writeback arbiter: ALU fixed priority, LSU/MDU round-robin.
// Define WB_SCOREBOARD_EN to build the pending-register scoreboard.
module regfile_wb_arbiter #(
    parameter int XLEN     = regfile_wb_arbiter_pkg::XLEN,
    parameter int NUM_REGS = regfile_wb_arbiter_pkg::NUM_REGS
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            lsu_valid,
    output logic            lsu_ready,
    input  logic [4:0]      lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    input  logic            mdu_valid,
    output logic            mdu_ready,
    input  logic [4:0]      mdu_rd,
    input  logic [XLEN-1:0] mdu_data,
    output logic            wb_wr_en,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    input  logic            issue_valid,
    input  logic [4:0]      issue_rd,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    output logic            rs1_busy,
    output logic            rs2_busy
);
    import regfile_wb_arbiter_pkg::*;

    typedef struct packed {
        logic [RD_W-1:0] rd;
        logic [XLEN-1:0] data;
    } wb_req_t;

    logic    [NUM_REQ-1:0] req_vld, req_rdy, req_gnt;
    wb_req_t [NUM_REQ-1:0] req;
    wb_req_t               wb_q, wb_d;
    logic                  wb_vld_q;
    rr_ptr_e               rr_q, rr_d;

    assign req_vld = {mdu_valid, lsu_valid, alu_valid};
    assign req     = {wb_req_t'{mdu_rd, mdu_data}, wb_req_t'{lsu_rd, lsu_data},
                      wb_req_t'{alu_rd, alu_data}};

    // Readies depend only on peer valids and the pointer, never on own valid/data.
    always_comb begin
        req_rdy = '0;
        if (reset) begin
            req_rdy[REQ_ALU] = 1'b1;
            req_rdy[REQ_LSU] = !alu_valid && (!mdu_valid || rr_q == FAV_LSU);
            req_rdy[REQ_MDU] = !alu_valid && (!lsu_valid || rr_q == FAV_MDU);
        end
    end

    assign req_gnt = req_vld & req_rdy;

    always_comb begin
        wb_d = wb_q;
        rr_d = rr_q;
        if (req_gnt[REQ_ALU]) begin
            wb_d = req[REQ_ALU];
        end else if (req_gnt[REQ_LSU]) begin
            wb_d = req[REQ_LSU];
            rr_d = FAV_MDU;
        end else if (req_gnt[REQ_MDU]) begin
            wb_d = req[REQ_MDU];
            rr_d = FAV_LSU;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wb_vld_q <= 1'b0;
            wb_q     <= '0;
            rr_q     <= FAV_LSU;
        end else begin
            wb_vld_q <= (|req_gnt) && (wb_d.rd != '0);
            wb_q     <= wb_d;
            rr_q     <= rr_d;
        end
    end

    assign alu_ready = req_rdy[REQ_ALU];
    assign lsu_ready = req_rdy[REQ_LSU];
    assign mdu_ready = req_rdy[REQ_MDU];

    // A writeback still in flight when reset asserts must not reach the regfile.
    assign wb_wr_en = wb_vld_q && reset;
    assign wb_rd    = wb_q.rd;
    assign wb_data  = wb_q.data;

`ifdef WB_SCOREBOARD_EN
    wb_scoreboard #(.NUM_REGS(NUM_REGS)) u_sb (
        .clk        (clk),
        .reset      (reset),
        .issue_valid(issue_valid),
        .issue_rd   (issue_rd),
        .wb_wr_en   (wb_wr_en),
        .wb_rd      (wb_rd),
        .rs1_addr   (rs1_addr),
        .rs2_addr   (rs2_addr),
        .rs1_busy   (rs1_busy),
        .rs2_busy   (rs2_busy)
    );
`else
    logic unused_sb;
    assign unused_sb = ^{issue_valid, issue_rd, rs1_addr, rs2_addr};
    assign rs1_busy  = 1'b0;
    assign rs2_busy  = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized bench for regfile_wb_arbiter against a cycle-level behavioural model.
module tb_regfile_wb_arbiter;
    import regfile_wb_arbiter_pkg::*;

    localparam int XW = XLEN;
`ifdef WB_SCOREBOARD_EN
    localparam bit SB = 1'b1;
`else
    localparam bit SB = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          alu_valid, lsu_valid, mdu_valid;
    logic          alu_ready, lsu_ready, mdu_ready;
    logic [4:0]    alu_rd, lsu_rd, mdu_rd;
    logic [XW-1:0] alu_data, lsu_data, mdu_data;
    logic          wb_wr_en;
    logic [4:0]    wb_rd;
    logic [XW-1:0] wb_data;
    logic          issue_valid;
    logic [4:0]    issue_rd, rs1_addr, rs2_addr;
    logic          rs1_busy, rs2_busy;

    regfile_wb_arbiter #(.XLEN(XW), .NUM_REGS(NUM_REGS)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_rd(mdu_rd), .mdu_data(mdu_data),
        .wb_wr_en(wb_wr_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model state: what the write port shows next cycle, who is favoured, which regs are pending.
    bit            m_en = 1'b0;
    logic [4:0]    m_rd = '0;
    logic [XW-1:0] m_data = '0;
    bit            m_fav_mdu = 1'b0;
    bit            m_pend [32];
    int            last_grant = -1;

    function automatic bit pend_busy(input logic [4:0] rs, input bit en);
        return (rs != 5'd0) && m_pend[rs] && !(en && m_rd == rs);
    endfunction

    // Checks the current cycle at the falling edge, then advances the model across the rising edge.
    task automatic cycle();
        int g;
        bit exp_en;
        @(negedge clk);
        g = -1;
        if (reset) begin
            if (alu_valid)                   g = REQ_ALU;
            else if (lsu_valid && mdu_valid) g = m_fav_mdu ? REQ_MDU : REQ_LSU;
            else if (lsu_valid)              g = REQ_LSU;
            else if (mdu_valid)              g = REQ_MDU;
        end
        if (alu_valid) chk("alu_ready", alu_ready, g == REQ_ALU);
        if (lsu_valid) chk("lsu_ready", lsu_ready, g == REQ_LSU);
        if (mdu_valid) chk("mdu_ready", mdu_ready, g == REQ_MDU);
        exp_en = m_en && reset;
        chk("wb_wr_en", wb_wr_en, exp_en);
        chk("wb_rd", wb_rd, m_rd);
        chk("wb_data", wb_data, m_data);
        chk("rs1_busy", rs1_busy, SB && pend_busy(rs1_addr, exp_en));
        chk("rs2_busy", rs2_busy, SB && pend_busy(rs2_addr, exp_en));
        last_grant = g;
        if (!reset) begin
            m_en = 1'b0; m_rd = '0; m_data = '0; m_fav_mdu = 1'b0;
            foreach (m_pend[i]) m_pend[i] = 1'b0;
        end else begin
            if (exp_en) m_pend[m_rd] = 1'b0;
            if (issue_valid && issue_rd != 5'd0) m_pend[issue_rd] = 1'b1;
            m_en = 1'b0;
            if (g == REQ_ALU) begin
                m_rd = alu_rd; m_data = alu_data;
            end else if (g == REQ_LSU) begin
                m_rd = lsu_rd; m_data = lsu_data; m_fav_mdu = 1'b1;
            end else if (g == REQ_MDU) begin
                m_rd = mdu_rd; m_data = mdu_data; m_fav_mdu = 1'b0;
            end
            if (g >= 0) m_en = (m_rd != 5'd0);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        foreach (m_pend[i]) m_pend[i] = 1'b0;
        reset = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 'h11;
        lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_data = 'h22;
        mdu_valid = 1'b1; mdu_rd = 5'd3; mdu_data = 'h33;
        issue_valid = 1'b1; issue_rd = 5'd3; rs1_addr = 5'd3; rs2_addr = 5'd2;
        @(posedge clk);
        #1;
        chk("rst_alu_ready", alu_ready, 0);
        chk("rst_lsu_ready", lsu_ready, 0);
        chk("rst_mdu_ready", mdu_ready, 0);
        chk("rst_wb_wr_en", wb_wr_en, 0);
        chk("rst_wb_rd", wb_rd, 0);
        chk("rst_rs1_busy", rs1_busy, 0);
        cycle();
        issue_valid = 1'b0;
        alu_valid = 1'b0;
        reset = 1'b1;

        // LSU and MDU both pending: grants alternate starting with LSU.
        lsu_rd = 5'd10; lsu_data = 'h100;
        mdu_rd = 5'd20; mdu_data = 'h200;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("rr_wb_rd", wb_rd, (i % 2 == 0) ? 10 + i / 2 : 20 + i / 2);
            if (i % 2 == 0) begin lsu_rd++; lsu_data++; end
            else            begin mdu_rd++; mdu_data++; end
        end
        lsu_valid = 1'b0; mdu_valid = 1'b0;
        cycle();
        chk("idle_wr_en", wb_wr_en, 0);
        chk("idle_rd_hold", wb_rd, 21);

        // ALU beats LSU; LSU follows next cycle.
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 'hAAAA;
        lsu_valid = 1'b1; lsu_rd = 5'd6; lsu_data = 'hBBBB;
        cycle();
        chk("alu_win_rd", wb_rd, 5);
        chk("alu_win_data", wb_data, 'hAAAA);
        chk("lsu_blocked", lsu_ready, 0);
        alu_valid = 1'b0;
        cycle();
        chk("lsu_next_en", wb_wr_en, 1);
        chk("lsu_next_rd", wb_rd, 6);
        chk("lsu_next_data", wb_data, 'hBBBB);
        lsu_valid = 1'b0;

        // Writes to x0 are consumed but not performed.
        mdu_valid = 1'b1; mdu_rd = 5'd0; mdu_data = 'h1234;
        chk("rd0_ready", mdu_ready, 1);
        cycle();
        chk("rd0_no_write", wb_wr_en, 0);
        mdu_valid = 1'b0;

        // Scoreboard: issue, bypass on writeback, same-cycle reissue.
        issue_valid = 1'b1; issue_rd = 5'd7; rs1_addr = 5'd7;
        cycle();
        issue_valid = 1'b0;
        chk("busy_after_issue", rs1_busy, SB);
        mdu_valid = 1'b1; mdu_rd = 5'd7; mdu_data = 'h77;
        cycle();
        mdu_valid = 1'b0;
        chk("busy_bypass", rs1_busy, 0);
        issue_valid = 1'b1; issue_rd = 5'd7;
        cycle();
        issue_valid = 1'b0;
        chk("busy_reissue", rs1_busy, SB);

        // A writeback in flight when reset asserts is dropped.
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 'h99;
        cycle();
        alu_valid = 1'b0;
        reset = 1'b0;
        #1;
        chk("rst_drop_wb", wb_wr_en, 0);
        cycle();
        reset = 1'b1;

        for (int n = 0; n < 3000; n++) begin
            if (!alu_valid || last_grant == REQ_ALU) begin
                alu_valid = ($urandom_range(0, 2) == 0);
                alu_rd = 5'($urandom_range(0, 31)); alu_data = XW'($urandom);
            end
            if (!lsu_valid || last_grant == REQ_LSU) begin
                lsu_valid = ($urandom_range(0, 1) == 0);
                lsu_rd = 5'($urandom_range(0, 31)); lsu_data = XW'($urandom);
            end
            if (!mdu_valid || last_grant == REQ_MDU) begin
                mdu_valid = ($urandom_range(0, 1) == 0);
                mdu_rd = 5'($urandom_range(0, 31)); mdu_data = XW'($urandom);
            end
            issue_valid = ($urandom_range(0, 2) == 0);
            issue_rd = 5'($urandom_range(0, 31));
            rs1_addr = 5'($urandom_range(0, 31));
            rs2_addr = 5'($urandom_range(0, 31));
            reset = ($urandom_range(0, 99) != 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default `XLEN (isa.v), data width.
REQ-002 SHALL have parameter NUM_REGS, default `NUM_REGS (isa.v), architectural register count (32).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous active-low reset, sampled on rising clk.
REQ-005 SHALL have ports alu_valid/alu_ready  input/output  1/1  ALU writeback handshake.
REQ-006 SHALL have ports alu_rd/alu_data  input  5/XLEN  ALU destination and result.
REQ-007 SHALL have ports lsu_valid, lsu_ready, lsu_rd, lsu_data  in/out/in/in  1/1/5/XLEN  load-unit writeback.
REQ-008 SHALL have ports mdu_valid, mdu_ready, mdu_rd, mdu_data  in/out/in/in  1/1/5/XLEN  mul/div writeback.
REQ-009 SHALL have ports wb_wr_en, wb_rd, wb_data  output  1/5/XLEN  regfile write port.
REQ-010 SHALL have ports issue_valid, issue_rd  input  1/5  long-latency op issued; mark rd pending.
REQ-011 SHALL have ports rs1_addr, rs2_addr  input  5/5  hazard query addresses.
REQ-012 SHALL have ports rs1_busy, rs2_busy  output  1/1  query register has a pending writeback.

Function
REQ-013 SHALL accept a requester when valid and ready are both high in the same cycle; ready SHALL be combinational from the grant, independent of own data.
REQ-014 SHALL grant at most one requester per cycle; ALU has fixed highest priority.
REQ-015 SHALL arbitrate LSU vs MDU round-robin: 1-bit pointer, flips to favour the other unit after any LSU or MDU grant.
REQ-016 SHALL register the granted request; wb_wr_en/wb_rd/wb_data valid exactly 1 cycle after acceptance.
REQ-017 SHALL drive wb_wr_en low when the accepted rd is 0; the request is still consumed (ready high).
REQ-018 SHALL drive wb_wr_en low in any cycle following a cycle with no acceptance; wb_rd/wb_data hold last value.
REQ-019 SHALL keep a ready low for every non-granted valid requester; requesters hold valid/rd/data until accepted.
REQ-020 SHALL keep pending bitmap: set bit issue_rd on issue_valid (rd!=0); clear bit wb_rd when wb_wr_en high.
REQ-021 SHALL give set priority when issue and clear target the same register in the same cycle.
REQ-022 SHALL compute rsN_busy = pending[rsN] AND NOT (wb_wr_en AND wb_rd==rsN); rsN==0 SHALL read not busy.
REQ-023 SHALL ignore issue_valid with issue_rd==0; bit 0 SHALL always read 0.

Reset
REQ-024 SHALL on reset low: pending=0, wb_wr_en=0, wb_rd=0, wb_data=0, rr pointer=LSU-favoured.
REQ-025 SHALL hold all readies low while reset is low; a writeback registered the cycle before reset asserts is dropped (wb_wr_en forced 0).

Configuration
REQ-026 SHALL compile scoreboard logic only when WB_SCOREBOARD_EN is defined.
REQ-027 SHALL, without WB_SCOREBOARD_EN, tie rs1_busy/rs2_busy to 0, ignore issue ports, and contain no pending state.

Structure
REQ-028 SHALL place requester IDs (ALU=0, LSU=1, MDU=2), XLEN, NUM_REGS in the shared isa.v constants.
REQ-029 SHALL use one sub-module wb_scoreboard (pending bitmap + busy query), instantiated under WB_SCOREBOARD_EN.

Verification
REQ-030 Reset low 2 cycles with all valids high -> all readies 0, wb_wr_en 0, busy 0.
REQ-031 ALU(rd=5,0xAAAA) and LSU(rd=6,0xBBBB) valid cycle 0 -> cycle 1 wb x5=0xAAAA, lsu_ready 0; cycle 2 wb x6=0xBBBB.
REQ-032 LSU and MDU valid 4 cycles, no ALU -> grants alternate LSU,MDU,LSU,MDU; wb_rd sequence matches.
REQ-033 MDU rd=0 data 0x1234 -> mdu_ready 1, next cycle wb_wr_en 0.
REQ-034 issue rd=7; query rs1=7 -> busy 1; MDU writes x7 -> busy 0 during wb cycle; same-cycle issue rd=7 -> busy 1 again after.
REQ-035 Build without WB_SCOREBOARD_EN, issue rd=3, query rs1=3 -> rs1_busy 0 throughout.
